// File: rtl/pocket_spi_seq.sv
// Command sequencer for the Pocket bridge 2-bit SPI shifter: queues 64-bit commands, frames each
// with slave-select, launches the shifter, waits for completion and assembles read-back data.
module pocket_spi_seq #(
    parameter int AW    = 2,
    parameter int SETUP = 1,
    parameter int HOLD  = 1,
    parameter int GAP   = 2,
    parameter int TMO   = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] cmd_din,
    input  logic        cmd_we,
    output logic        cmd_full,
    output logic        cmd_empty,
    output logic        busy,
    output logic        spi_wr,
    output logic [63:0] spi_din,
    output logic        spi_cen,
    output logic        spi_ss,
    input  logic        spi_idle,
    input  logic        spi_rding,
    input  logic [1:0]  bus_din,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        err
);
    localparam int DEPTH = 1 << AW;
    localparam int CMAX  = (TMO > 16) ? TMO : 16;
    localparam int CW    = $clog2(CMAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAITB, S_SHIFT, S_HOLD, S_REL} state_t;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fill;
    logic          push;
    logic          pop;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [31:0]   rd_sh;
    logic [31:0]   rd_sh_nxt;
    logic [31:0]   rd_data_nxt;
    logic [63:0]   spi_din_nxt;
    logic          ss_nxt;
    logic          cen_nxt;
    logic          wr_nxt;
    logic          rv_nxt;
    logic          err_nxt;

    assign cmd_full  = (fill == (AW+1)'(DEPTH));
    assign cmd_empty = (fill == '0);
    assign busy      = (state != S_IDLE);
    assign pop       = (state == S_IDLE) && !cmd_empty && spi_idle;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push      = cmd_we && (!cmd_full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fill <= fill + 1'b1;
            else if (pop && !push)
                fill <= fill - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= cmd_din;
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rd_sh_nxt   = rd_sh;
        rd_data_nxt = rd_data;
        spi_din_nxt = spi_din;
        ss_nxt      = spi_ss;
        cen_nxt     = spi_cen;
        wr_nxt      = 1'b0;
        rv_nxt      = 1'b0;
        err_nxt     = err;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    spi_din_nxt = mem[rd_ptr];
                    rd_sh_nxt   = '0;
                    ss_nxt      = 1'b0;
                    cnt_nxt     = '0;
                    state_nxt   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt == CW'(SETUP - 1)) begin
                    wr_nxt    = 1'b1;
                    cen_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_WAITB;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WAITB: begin
                if (!spi_idle) begin
                    state_nxt = S_SHIFT;
                end else if (cnt == CW'(TMO - 1)) begin
                    // Shifter never started: abandon the command without a read result.
                    err_nxt   = 1'b1;
                    cen_nxt   = 1'b0;
                    ss_nxt    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_REL;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                if (spi_rding)
                    rd_sh_nxt = {bus_din, rd_sh[31:2]};
                if (spi_idle) begin
                    cen_nxt = 1'b0;
                    cnt_nxt = '0;
                    if (HOLD == 0) begin
                        ss_nxt    = 1'b1;
                        state_nxt = S_REL;
                        if (!spi_din[0]) begin
                            rd_data_nxt = rd_sh_nxt;
                            rv_nxt      = 1'b1;
                        end
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (cnt == CW'(HOLD - 1)) begin
                    ss_nxt    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_REL;
                    if (!spi_din[0]) begin
                        rd_data_nxt = rd_sh;
                        rv_nxt      = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_REL: begin
                if (cnt == CW'(GAP - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rd_sh    <= '0;
            rd_data  <= '0;
            spi_din  <= '0;
            spi_ss   <= 1'b1;
            spi_cen  <= 1'b0;
            spi_wr   <= 1'b0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rd_sh    <= rd_sh_nxt;
            rd_data  <= rd_data_nxt;
            spi_din  <= spi_din_nxt;
            spi_ss   <= ss_nxt;
            spi_cen  <= cen_nxt;
            spi_wr   <= wr_nxt;
            rd_valid <= rv_nxt;
            err      <= err_nxt;
        end
    end
endmodule

// File: tb/tb_pocket_spi_seq.sv
// Directed and randomized bench for pocket_spi_seq with a behavioural shifter/target model and
// an arithmetic reference for the read-back word.
module tb_pocket_spi_seq;
    localparam int AW    = 2;
    localparam int SETUP = 1;
    localparam int HOLD  = 1;
    localparam int GAP   = 2;
    localparam int TMO   = 63;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] cmd_din = '0;
    logic        cmd_we = 1'b0;
    logic        cmd_full;
    logic        cmd_empty;
    logic        busy;
    logic        spi_wr;
    logic [63:0] spi_din;
    logic        spi_cen;
    logic        spi_ss;
    logic        spi_idle = 1'b1;
    logic        spi_rding = 1'b0;
    logic [1:0]  bus_din = 2'b00;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        err;

    int errors = 0;
    int checks = 0;

    // Shifter/target model settings: idle stays low for sh_len cycles after the launch strobe;
    // read pairs are driven during phases [rd_start, rd_start+rd_len).
    int          sh_len = 32;
    int          rd_start = 1;
    int          rd_len = 0;
    bit          hang = 1'b0;
    bit          block = 1'b0;
    logic [1:0]  pairs [32];
    int          ph = 0;
    bit          run = 1'b0;

    logic [31:0] exp_rd = '0;
    int          rv_cnt = 0;
    int          exp_rv = 0;

    pocket_spi_seq #(.AW(AW), .SETUP(SETUP), .HOLD(HOLD), .GAP(GAP), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .cmd_din(cmd_din), .cmd_we(cmd_we),
        .cmd_full(cmd_full), .cmd_empty(cmd_empty), .busy(busy),
        .spi_wr(spi_wr), .spi_din(spi_din), .spi_cen(spi_cen), .spi_ss(spi_ss),
        .spi_idle(spi_idle), .spi_rding(spi_rding), .bus_din(bus_din),
        .rd_data(rd_data), .rd_valid(rd_valid), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rd_valid === 1'b1) rv_cnt++;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            run = 1'b0; spi_idle = 1'b1; spi_rding = 1'b0; bus_din = 2'b00;
        end else if (run) begin
            ph++;
            if (ph >= sh_len) begin
                run = 1'b0; spi_idle = 1'b1; spi_rding = 1'b0; bus_din = 2'b00;
            end else if (ph >= rd_start && ph < rd_start + rd_len) begin
                spi_rding = 1'b1; bus_din = pairs[ph - rd_start];
            end else begin
                spi_rding = 1'b0; bus_din = 2'($urandom_range(0, 3));
            end
        end else if (spi_wr === 1'b1 && !hang) begin
            run = 1'b1; ph = 0; spi_idle = 1'b0; spi_rding = 1'b0;
        end else begin
            spi_idle = !block;
        end
    end

    // Read word from n LSB-first pairs: the last min(n,16) survive, the oldest sitting lowest,
    // packed against bit 31.
    function automatic logic [31:0] model_rd(input int n);
        logic [31:0] v;
        int m;
        v = '0;
        m = (n < 16) ? n : 16;
        for (int j = 0; j < m; j++)
            v |= 32'(pairs[n - m + j]) << (32 - 2 * m + 2 * j);
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] c);
        cmd_din = c;
        cmd_we  = 1'b1;
        @(negedge clk);
        cmd_we  = 1'b0;
    endtask

    task automatic rand_pairs();
        for (int j = 0; j < 32; j++) pairs[j] = 2'($urandom_range(0, 3));
    endtask

    task automatic frame(input string tag, input logic [63:0] cmd, output int highs);
        int n;
        bit rdcmd;
        rdcmd = !cmd[0];
        highs = 0;
        while (spi_ss !== 1'b0 && highs < 300) begin @(negedge clk); highs++; end
        check({tag, " ss_fall"}, spi_ss, 1'b0);
        n = 0;
        while (spi_wr !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        check({tag, " setup"}, n, SETUP);
        check({tag, " din"}, spi_din, cmd);
        check({tag, " cen_on"}, spi_cen, 1'b1);
        if (rdcmd) exp_rd = model_rd(rd_len);
        @(negedge clk);
        check({tag, " wr_pulse"}, spi_wr, 1'b0);
        n = 0;
        while (spi_idle !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        n = 0;
        while (spi_ss !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        check({tag, " hold"}, n, HOLD);
        check({tag, " cen_off"}, spi_cen, 1'b0);
        check({tag, " din_stable"}, spi_din, cmd);
        check({tag, " rv"}, rd_valid, rdcmd);
        check({tag, " rd_data"}, rd_data, exp_rd);
        if (rdcmd) exp_rv++;
        @(negedge clk);
        check({tag, " rv_pulse"}, rd_valid, 1'b0);
    endtask

    initial begin
        int hi;
        int n;
        logic [63:0] c;
        logic [63:0] q[$];

        repeat (2) @(negedge clk);
        check("rst ss", spi_ss, 1'b1);
        check("rst wr", spi_wr, 1'b0);
        check("rst cen", spi_cen, 1'b0);
        check("rst rv", rd_valid, 1'b0);
        check("rst err", err, 1'b0);
        check("rst rd_data", rd_data, 32'h0);
        check("rst din", spi_din, 64'h0);
        check("rst empty", cmd_empty, 1'b1);
        check("rst full", cmd_full, 1'b0);
        check("rst busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        sh_len = 32; rd_start = 1; rd_len = 0;
        push(64'h8000_0004_0000_0001);
        frame("write", 64'h8000_0004_0000_0001, hi);

        for (int j = 0; j < 16; j++) begin
            c = 64'h1234_5678 >> (2 * j);
            pairs[j] = c[1:0];
        end
        rd_start = 4; rd_len = 16; sh_len = 32;
        push(64'hf800_0000_0000_0000);
        frame("read", 64'hf800_0000_0000_0000, hi);
        check("read value", rd_data, 32'h1234_5678);

        // Randomized batches; later commands are pushed while the first is in flight.
        for (int b = 0; b < 4; b++) begin
            rd_start = $urandom_range(1, 4);
            rd_len   = $urandom_range(1, 24);
            sh_len   = rd_start + rd_len + $urandom_range(0, 5);
            q.delete();
            for (int i = 0; i < 3; i++) q.push_back({$urandom, $urandom});
            rand_pairs();
            push(q[0]);
            fork
                frame($sformatf("rnd%0d_0", b), q[0], hi);
                begin
                    repeat (3) @(negedge clk);
                    push(q[1]);
                    push(q[2]);
                end
            join
            for (int i = 1; i < 3; i++) begin
                rand_pairs();
                frame($sformatf("rnd%0d_%0d", b, i), q[i], hi);
            end
        end
        check("rv count rnd", rv_cnt, exp_rv);

        block = 1'b1;
        sh_len = 6; rd_start = 1; rd_len = 4;
        rand_pairs();
        repeat (3) @(negedge clk);
        q.delete();
        for (int i = 0; i < 4; i++) begin
            c = {$urandom, $urandom};
            c[0] = (i != 2);
            q.push_back(c);
        end
        for (int i = 0; i < 4; i++) begin
            cmd_din = q[i];
            cmd_we  = 1'b1;
            @(negedge clk);
        end
        check("full after 4", cmd_full, 1'b1);
        cmd_din = 64'hdead_beef_dead_beef;
        @(negedge clk);
        cmd_we = 1'b0;
        check("full after 5th", cmd_full, 1'b1);
        check("not empty", cmd_empty, 1'b0);
        block = 1'b0;
        for (int i = 0; i < 4; i++) begin
            frame($sformatf("b2b%0d", i), q[i], hi);
            if (i > 0) check($sformatf("b2b%0d gap", i), (hi + 1 >= GAP), 1'b1);
        end
        n = 0;
        repeat (30) begin @(negedge clk); if (spi_ss !== 1'b1) n++; end
        check("no 5th frame", n, 0);
        check("empty after b2b", cmd_empty, 1'b1);

        hang = 1'b1;
        c = {$urandom, $urandom};
        c[0] = 1'b0;
        push(c);
        n = 0;
        while (spi_wr !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        check("tmo wr", spi_wr, 1'b1);
        check("tmo din", spi_din, c);
        n = 0;
        while (err !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("tmo cycles", n, TMO);
        check("tmo ss", spi_ss, 1'b1);
        check("tmo cen", spi_cen, 1'b0);
        hang = 1'b0;
        repeat (2) @(negedge clk);
        check("tmo rv count", rv_cnt, exp_rv);

        rd_start = 2; rd_len = 16; sh_len = 20;
        rand_pairs();
        c = {$urandom, $urandom};
        c[0] = 1'b0;
        push(c);
        frame("post tmo", c, hi);
        check("err sticky", err, 1'b1);

        rd_start = 2; rd_len = 16; sh_len = 40;
        rand_pairs();
        c = {$urandom, $urandom};
        c[0] = 1'b0;
        push(c);
        push({$urandom, $urandom});
        push({$urandom, $urandom});
        n = 0;
        while (spi_wr !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        repeat (8) @(negedge clk);
        check("mid shift cen", spi_cen, 1'b1);
        check("mid shift queued", cmd_empty, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("arst ss", spi_ss, 1'b1);
        check("arst cen", spi_cen, 1'b0);
        check("arst empty", cmd_empty, 1'b1);
        check("arst busy", busy, 1'b0);
        check("arst err", err, 1'b0);
        check("arst rd_data", rd_data, 32'h0);
        check("arst din", spi_din, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (80) begin @(negedge clk); if (spi_ss !== 1'b1) n++; end
        check("post rst no frame", n, 0);
        check("post rst rv count", rv_cnt, exp_rv);
        check("post rst rd_data", rd_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
